// File: rtl/seq_stage_controller_pkg.sv
// Shared definitions for the Y86-64 SEQ sequencer and its neighbouring stages:
// instruction codes, processor status codes, sequencer states, stage strobes.
package seq_stage_controller_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned STAT_W  = 3;

  // Y86-64 instruction codes (icode field)
  localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
  localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
  localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
  localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
  localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

  // Processor status
  typedef enum logic [STAT_W-1:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  // One-hot stage strobe bundle
  typedef struct packed {
    logic fetch;
    logic decode;
    logic execute;
    logic memory;
    logic writeback;
  } stage_en_t;

  // Instructions that touch data memory
  function automatic logic needs_mem(input logic [ICODE_W-1:0] icode);
    logic r;
    r = 1'b0;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Stage strobe pattern for a state; IDLE, PCUPD and HALT have none
  function automatic stage_en_t stage_en_of(input state_t s);
    stage_en_t e;
    e = '0;
    case (s)
      S_FETCH:     e.fetch     = 1'b1;
      S_DECODE:    e.decode    = 1'b1;
      S_EXECUTE:   e.execute   = 1'b1;
      S_MEMORY:    e.memory    = 1'b1;
      S_WRITEBACK: e.writeback = 1'b1;
      default:     e = '0;
    endcase
    return e;
  endfunction

  // Busy in every state except IDLE and HALT
  function automatic logic is_busy(input state_t s);
    return !((s == S_IDLE) || (s == S_HALT));
  endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Next-PC selection for the SEQ core. Pure mux, no arithmetic.
//   i_icode   instruction code
//   i_cnd     jump condition
//   i_valc    constant word / jump or call target
//   i_valm    memory word (return address)
//   i_valp    fall-through address
//   o_next_pc_c  selected next PC (combinational)
module seq_next_pc
  import seq_stage_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ICODE_W-1:0] i_icode,
  input  logic               i_cnd,
  input  logic [ADDR_W-1:0]  i_valc,
  input  logic [ADDR_W-1:0]  i_valm,
  input  logic [ADDR_W-1:0]  i_valp,
  output logic [ADDR_W-1:0]  o_next_pc_c
);

  // call -> target, ret -> popped address, taken jXX -> target, else fall through
  always_comb begin
    o_next_pc_c = i_valp;
    case (i_icode)
      I_CALL:  o_next_pc_c = i_valc;
      I_RET:   o_next_pc_c = i_valm;
      I_JXX:   o_next_pc_c = i_cnd ? i_valc : i_valp;
      default: o_next_pc_c = i_valp;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ core. Steps one instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PC-UPDATE, owns PC and stat, runs the
// data-memory req/ack handshake with timeout, and keeps busy-cycle and
// retired-instruction counters.
//   clk, rst_n          clock, async active-low reset
//   start               leave IDLE and begin fetching
//   icode, cnd          decoded instruction code, branch condition
//   valC, valM, valP    target / memory word / fall-through address
//   imem_error, instr_valid  fetch status, sampled in FETCH
//   dmem_ack, dmem_error     data memory handshake
//   pc                  architectural PC
//   *_en                one-hot stage strobes
//   dmem_req            data memory request (high throughout MEMORY)
//   stat                AOK/HLT/ADR/INS
//   busy                not IDLE and not HALT
//   cycle_count, instr_count  saturating counters
module seq_stage_controller
  import seq_stage_controller_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ICODE_W-1:0] icode,
  input  logic               cnd,
  input  logic [ADDR_W-1:0]  valC,
  input  logic [ADDR_W-1:0]  valM,
  input  logic [ADDR_W-1:0]  valP,
  input  logic               imem_error,
  input  logic               instr_valid,
  input  logic               dmem_ack,
  input  logic               dmem_error,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               execute_en,
  output logic               memory_en,
  output logic               writeback_en,
  output logic               dmem_req,
  output logic [STAT_W-1:0]  stat,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  stat_t             r_stat;
  stat_t             w_next_stat;
  stage_en_t         r_stage_en;
  logic              r_dmem_req;
  logic              r_busy;
  logic              w_retire;
  logic              w_mem_timeout;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_instr_count;

  seq_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .i_icode     (icode),
    .i_cnd       (cnd),
    .i_valc      (valC),
    .i_valm      (valM),
    .i_valp      (valP),
    .o_next_pc_c (w_next_pc)
  );

  // r_wait counts completed MEMORY cycles; this is the last one allowed
  assign w_mem_timeout = (r_wait == WAIT_LAST);

  // Next state and status
  always_comb begin
    w_next_state = r_state;
    w_next_stat  = r_stat;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          w_next_stat  = STAT_ADR;
          w_next_state = S_HALT;
        end else if (!instr_valid) begin
          w_next_stat  = STAT_INS;
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (icode == I_HALT) begin
          w_next_stat  = STAT_HLT;
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_next_state = needs_mem(icode) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        // an ack on the final allowed cycle still completes the access
        if (dmem_ack) begin
          if (dmem_error) begin
            w_next_stat  = STAT_ADR;
            w_next_state = S_HALT;
          end else begin
            w_next_state = S_WRITEBACK;
          end
        end else if (w_mem_timeout) begin
          w_next_stat  = STAT_ADR;
          w_next_state = S_HALT;
        end
      end
      S_WRITEBACK: begin
        w_next_state = S_PCUPD;
      end
      S_PCUPD: begin
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, PC, counters; strobes/req/busy registered from the next state so
  // they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_stat        <= STAT_AOK;
      r_pc          <= RESET_PC;
      r_stage_en    <= '0;
      r_dmem_req    <= 1'b0;
      r_busy        <= 1'b0;
      r_wait        <= '0;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_stat     <= w_next_stat;
      r_stage_en <= stage_en_of(w_next_state);
      r_dmem_req <= (w_next_state == S_MEMORY);
      r_busy     <= is_busy(w_next_state);
      // zero outside MEMORY so every MEMORY entry starts a fresh wait
      r_wait     <= (r_state == S_MEMORY) ? (r_wait + WAIT_W'(1)) : '0;
      if (w_retire) begin
        r_pc <= w_next_pc;
      end
      if (r_busy && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_retire && (r_instr_count != '1)) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign pc           = r_pc;
  assign fetch_en     = r_stage_en.fetch;
  assign decode_en    = r_stage_en.decode;
  assign execute_en   = r_stage_en.execute;
  assign memory_en    = r_stage_en.memory;
  assign writeback_en = r_stage_en.writeback;
  assign dmem_req     = r_dmem_req;
  assign stat         = r_stat;
  assign busy         = r_busy;
  assign cycle_count  = r_cycle_count;
  assign instr_count  = r_instr_count;

endmodule
